case_6_sdiv_seq_9s_9s_9: RTL and testbench

CASE_6_SDIV_SEQ_9S_9S_9 -- requirements
Module: case_6_sdiv_seq_9s_9s_9

---
 rtl/case_6_sdiv_seq_9s_9s_9.sv | 148 ++++++++++++++
 tb/tb_case_6_sdiv_seq_9s_9s_9.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/case_6_sdiv_seq_9s_9s_9.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// with sign correction applied when the result is latched.
module case_6_sdiv_seq_9s_9s_9 #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 10,
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [dout_WIDTH-1:0] remd
);

    localparam int W  = din0_WIDTH;
    localparam int MW = din0_WIDTH + 1;
    localparam int CW = $clog2(din0_WIDTH + 1);

    localparam logic [CW-1:0] LAST  = CW'(W);
    localparam logic [CW-1:0] ONE_C = 1;
    localparam logic [W-1:0]  ONE_W = 1;
    localparam logic [MW-1:0] ONE_M = 1;

    if (ID < 0 || NUM_STAGE < 1 || din1_WIDTH > din0_WIDTH
        || dout_WIDTH != din0_WIDTH) begin : g_cfg_bad
        $error("case_6_sdiv_seq_9s_9s_9: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [MW-1:0] dvs;
    logic          neg0;
    logic          neg1;

    logic [MW-1:0] ext0;
    logic [MW-1:0] ext1;
    logic [MW-1:0] mag0;
    logic [MW-1:0] mag1;
    logic [MW-1:0] trial;
    logic          ge;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  quo_fix;
    logic [W-1:0]  rem_fix;

    // Magnitudes are taken one bit wider so the most-negative value negates cleanly
    always_comb begin
        ext0 = {din0[W-1], din0};
        ext1 = {{(MW - din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
        mag0 = ext0[MW-1] ? (~ext0 + ONE_M) : ext0;
        mag1 = ext1[MW-1] ? (~ext1 + ONE_M) : ext1;
    end

    always_comb begin
        trial  = {rem, quo[W-1]};
        ge     = (trial >= dvs);
        rem_nx = ge ? W'(trial - dvs) : trial[W-1:0];
    end

    // Divide-by-zero forces an all-ones quotient regardless of dividend sign
    always_comb begin
        if (dvs == '0) begin
            quo_fix = '1;
        end else if (neg0 ^ neg1) begin
            quo_fix = ~quo + ONE_W;
        end else begin
            quo_fix = quo;
        end
        rem_fix = neg0 ? (~rem + ONE_W) : rem;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nx;
        end
    end

    // Counter runs 0..W: W iterations, then one cycle to latch the corrected result
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
            neg0 <= 1'b0;
            neg1 <= 1'b0;
            dout <= '0;
            remd <= '0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        quo  <= W'(mag0);
                        dvs  <= mag1;
                        rem  <= '0;
                        neg0 <= din0[W-1];
                        neg1 <= din1[din1_WIDTH-1];
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    if (cnt == LAST) begin
                        dout <= quo_fix;
                        remd <= rem_fix;
                        cnt  <= '0;
                    end else begin
                        quo <= {quo[W-2:0], ge};
                        rem <= rem_nx;
                        cnt <= cnt + ONE_C;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_case_6_sdiv_seq_9s_9s_9.sv
// Scoreboard bench for the sequential signed divider: driver pushes
// hand-computed results, a negedge monitor pops them on each done.
module tb_case_6_sdiv_seq_9s_9s_9;

    typedef struct {
        logic [8:0] q;
        logic [8:0] r;
        int         cyc;
    } exp_t;

    logic       ap_clk;
    logic       ap_rst;
    logic       ce;
    logic       start;
    logic [8:0] din0;
    logic [8:0] din1;
    logic       ready;
    logic       done;
    logic [8:0] dout;
    logic [8:0] remd;

    int   total;
    int   bad;
    int   cyc;
    logic done_q;
    exp_t sbq[$];

    localparam int NV = 12;
    localparam logic [8:0] VA[NV] = '{9'h064, 9'h19C, 9'h064, 9'h19C,
                                      9'h005, 9'h100, 9'h100, 9'h1FB,
                                      9'h0FF, 9'h100, 9'h000, 9'h1FF};
    localparam logic [8:0] VB[NV] = '{9'h007, 9'h007, 9'h1F9, 9'h1F9,
                                      9'h000, 9'h1FF, 9'h001, 9'h000,
                                      9'h100, 9'h100, 9'h003, 9'h002};
    localparam logic [8:0] VQ[NV] = '{9'h00E, 9'h1F2, 9'h1F2, 9'h00E,
                                      9'h1FF, 9'h100, 9'h100, 9'h1FF,
                                      9'h000, 9'h001, 9'h000, 9'h000};
    localparam logic [8:0] VR[NV] = '{9'h002, 9'h1FE, 9'h002, 9'h1FE,
                                      9'h005, 9'h000, 9'h000, 9'h1FB,
                                      9'h0FF, 9'h000, 9'h000, 9'h1FF};

    case_6_sdiv_seq_9s_9s_9 dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .ce     (ce),
        .start  (start),
        .din0   (din0),
        .din1   (din1),
        .ready  (ready),
        .done   (done),
        .dout   (dout),
        .remd   (remd)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endfunction

    initial done_q = 1'b0;
    always @(negedge ap_clk) begin
        exp_t e;
        if (!ap_rst && done && !done_q) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: dout=0x%0h remd=0x%0h",
                         dout, remd);
            end else begin
                e = sbq.pop_front();
                chk("dout", int'(dout), int'(e.q));
                chk("remd", int'(remd), int'(e.r));
                chk("done_cycle", cyc, e.cyc);
            end
        end
        done_q = done;
    end

    task automatic issue(input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] q, input logic [8:0] r,
                         input int extra);
        int k;
        exp_t e;
        k = 0;
        while (!ready && k < 100) begin
            @(negedge ap_clk);
            k++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
        din0  = a;
        din1  = b;
        start = 1'b1;
        e.q   = q;
        e.r   = r;
        e.cyc = cyc + 11 + extra;
        sbq.push_back(e);
        @(negedge ap_clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 400) begin
            @(negedge ap_clk);
            k++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        ap_rst = 1'b1;
        ce     = 1'b1;
        start  = 1'b0;
        din0   = '0;
        din1   = '0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_remd", int'(remd), 0);

        // Directed vectors, issued as soon as the divider is ready again
        for (int i = 0; i < NV; i++) begin
            issue(VA[i], VB[i], VQ[i], VR[i], 0);
        end
        drain();

        // Start while busy must not disturb the running division
        issue(9'h064, 9'h007, 9'h00E, 9'h002, 0);
        repeat (2) @(negedge ap_clk);
        din0  = 9'h1CE;
        din1  = 9'h003;
        start = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        drain();

        // Clock-enable stall of three cycles mid-calculation
        issue(9'h19C, 9'h1F9, 9'h00E, 9'h1FE, 3);
        repeat (3) @(negedge ap_clk);
        ce = 1'b0;
        repeat (3) @(negedge ap_clk);
        ce = 1'b1;
        drain();

        // Reset during iteration 4 abandons the operation
        issue(9'h064, 9'h1F9, 9'h1F2, 9'h002, 0);
        repeat (3) @(negedge ap_clk);
        void'(sbq.pop_back());
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("mid_rst_ready", int'(ready), 1);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_remd", int'(remd), 0);
        issue(9'h100, 9'h001, 9'h100, 9'h000, 0);
        drain();

        repeat (20) @(negedge ap_clk);
        chk("queue_empty", sbq.size(), 0);
        chk("final_ready", int'(ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
